// File: rtl/nnrv_lsu.sv
// nnrv_lsu -- load/store unit between the execute stage and the data RAM.
//
// Takes one memory request per valid/ready handshake, checks opcode legality
// and alignment, drives a single-cycle RAM access with byte-lane masks, and
// hands every request (load or store) back to writeback as a held response.
//
// Handshake rule for both request and response channels: a transfer happens
// on the rising clock edge where valid and ready are both 1. The producer
// keeps valid and its payload stable until that edge. The response channel
// holds all o_rsp_* stable while o_rsp_valid=1 and i_rsp_ready=0.
//
// Ports:
//   i_clk, i_rst_n        clock (posedge) and asynchronous active-low reset
//   i_req_valid/o_req_ready, i_req_op/addr/wdata/rd       request channel
//   o_rsp_valid/i_rsp_ready, o_rsp_rdata/rd/is_load/exc   response channel
//   o_ram_rd_en/addr/mask, i_ram_rd_data                  RAM read port
//   o_ram_wr_en/addr/mask/data                            RAM write port
//   o_dbg_state           current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
//
// i_req_op: [3]=store, [2:0]=funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
// o_rsp_exc: 00 ok, 01 misaligned, 10 illegal op.

module nnrv_lsu #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = DATA_WIDTH >> 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,

    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [3:0]            i_req_op,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    input  logic [4:0]            i_req_rd,

    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic [4:0]            o_rsp_rd,
    output logic                  o_rsp_is_load,
    output logic [1:0]            o_rsp_exc,

    output logic                  o_ram_rd_en,
    output logic [ADDR_WIDTH-1:0] o_ram_rd_addr,
    output logic [MASK_WIDTH-1:0] o_ram_rd_mask,
    input  logic [DATA_WIDTH-1:0] i_ram_rd_data,

    output logic                  o_ram_wr_en,
    output logic [ADDR_WIDTH-1:0] o_ram_wr_addr,
    output logic [MASK_WIDTH-1:0] o_ram_wr_mask,
    output logic [DATA_WIDTH-1:0] o_ram_wr_data,

    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;

    // Latched request
    logic [3:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [4:0]            rd_q;

    // Decode of the latched request (only meaningful in ACCESS)
    logic                  is_store;
    logic [2:0]            funct3;
    logic                  legal;
    logic                  misaligned;
    logic [1:0]            exc;
    logic [MASK_WIDTH-1:0] byte_mask;
    logic [4:0]            lane_shift;
    logic [DATA_WIDTH-1:0] load_sh;
    logic [DATA_WIDTH-1:0] load_ext;
    logic                  access_ok;
    logic                  accept;

    always_comb begin
        is_store   = op_q[3];
        funct3     = op_q[2:0];

        legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !is_store;  // unsigned forms are load-only
            default:                legal = 1'b0;
        endcase

        // funct3[1:0] encodes the access size for every legal op
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = addr_q[0];
            2'b10:   misaligned = (addr_q[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        // Illegal op outranks misalignment: size bits of an illegal op mean nothing
        if (!legal)          exc = 2'b10;
        else if (misaligned) exc = 2'b01;
        else                 exc = 2'b00;

        case (funct3[1:0])
            2'b00:   byte_mask = {{(MASK_WIDTH-1){1'b0}}, 1'b1} << addr_q[1:0];
            2'b01:   byte_mask = {{(MASK_WIDTH-2){1'b0}}, 2'b11} << addr_q[1:0];
            default: byte_mask = '1;
        endcase

        lane_shift = {addr_q[1:0], 3'b000};
        load_sh    = i_ram_rd_data >> lane_shift;

        case (funct3)
            3'b000:  load_ext = {{(DATA_WIDTH-8){load_sh[7]}}, load_sh[7:0]};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, load_sh[7:0]};
            3'b001:  load_ext = {{(DATA_WIDTH-16){load_sh[15]}}, load_sh[15:0]};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, load_sh[15:0]};
            default: load_ext = load_sh;
        endcase

        access_ok = (state == ACCESS) && (exc == 2'b00);
    end

    // RAM ports: everything is zero unless this is a clean ACCESS cycle
    always_comb begin
        o_ram_wr_en   = access_ok && is_store;
        o_ram_wr_addr = o_ram_wr_en ? addr_q : '0;
        o_ram_wr_mask = o_ram_wr_en ? byte_mask : '0;
        o_ram_wr_data = o_ram_wr_en ? (wdata_q << lane_shift) : '0;

        o_ram_rd_en   = access_ok && !is_store;
        o_ram_rd_addr = o_ram_rd_en ? addr_q : '0;
        o_ram_rd_mask = o_ram_rd_en ? byte_mask : '0;
    end

    // Ready in RESP follows i_rsp_ready so a new request can overlap the
    // response hand-off, giving one request every two cycles.
    assign o_req_ready = (state == IDLE) || ((state == RESP) && i_rsp_ready);
    assign o_rsp_valid = (state == RESP);
    assign accept      = i_req_valid && o_req_ready;
    assign o_dbg_state = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            op_q          <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rd_q          <= '0;
            o_rsp_rdata   <= '0;
            o_rsp_rd      <= '0;
            o_rsp_is_load <= 1'b0;
            o_rsp_exc     <= 2'b00;
        end else begin
            if (accept) begin
                op_q    <= i_req_op;
                addr_q  <= i_req_addr;
                wdata_q <= i_req_wdata;
                rd_q    <= i_req_rd;
            end

            case (state)
                IDLE: begin
                    if (accept) state <= ACCESS;
                end
                ACCESS: begin
                    o_rsp_rd      <= rd_q;
                    o_rsp_is_load <= !is_store;
                    o_rsp_exc     <= exc;
                    o_rsp_rdata   <= (exc == 2'b00 && !is_store) ? load_ext : '0;
                    state         <= RESP;
                end
                RESP: begin
                    if (i_rsp_ready) state <= accept ? ACCESS : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nnrv_lsu.sv
// Directed testbench for nnrv_lsu with a small byte-masked RAM model.

module tb_nnrv_lsu;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [3:0]  i_req_op;
    logic [7:0]  i_req_addr;
    logic [31:0] i_req_wdata;
    logic [4:0]  i_req_rd;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic [4:0]  o_rsp_rd;
    logic        o_rsp_is_load;
    logic [1:0]  o_rsp_exc;
    logic        o_ram_rd_en;
    logic [7:0]  o_ram_rd_addr;
    logic [3:0]  o_ram_rd_mask;
    logic [31:0] i_ram_rd_data;
    logic        o_ram_wr_en;
    logic [7:0]  o_ram_wr_addr;
    logic [3:0]  o_ram_wr_mask;
    logic [31:0] o_ram_wr_data;
    logic [1:0]  o_dbg_state;

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;

    logic [31:0] mem [64];

    // Values captured by do_req
    logic        acc_wr_en, acc_rd_en;
    logic [3:0]  acc_wr_mask, acc_rd_mask;
    logic [31:0] acc_wr_data;
    logic [7:0]  acc_wr_addr, acc_rd_addr;
    logic        got_valid, got_is_load, req_ready_seen;
    logic [31:0] got_rdata;
    logic [4:0]  got_rd;
    logic [1:0]  got_exc;

    nnrv_lsu #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MASK_WIDTH(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_op(i_req_op), .i_req_addr(i_req_addr),
        .i_req_wdata(i_req_wdata), .i_req_rd(i_req_rd),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_rd(o_rsp_rd),
        .o_rsp_is_load(o_rsp_is_load), .o_rsp_exc(o_rsp_exc),
        .o_ram_rd_en(o_ram_rd_en), .o_ram_rd_addr(o_ram_rd_addr),
        .o_ram_rd_mask(o_ram_rd_mask), .i_ram_rd_data(i_ram_rd_data),
        .o_ram_wr_en(o_ram_wr_en), .o_ram_wr_addr(o_ram_wr_addr),
        .o_ram_wr_mask(o_ram_wr_mask), .o_ram_wr_data(o_ram_wr_data),
        .o_dbg_state(o_dbg_state)
    );

    // Clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // RAM model: combinational masked read, byte-masked write on posedge
    always_comb begin
        i_ram_rd_data = mem[o_ram_rd_addr[7:2]];
        for (int b = 0; b < 4; b++)
            if (!o_ram_rd_mask[b]) i_ram_rd_data[8*b +: 8] = 8'h00;
    end

    always @(posedge i_clk) begin
        if (o_ram_wr_en) begin
            wr_pulses <= wr_pulses + 1;
            for (int b = 0; b < 4; b++)
                if (o_ram_wr_mask[b]) mem[o_ram_wr_addr[7:2]][8*b +: 8] <= o_ram_wr_data[8*b +: 8];
        end
        if (o_ram_rd_en) rd_pulses <= rd_pulses + 1;
    end

    // Driver: one full request/response, fixed latency, no open-ended waits
    task automatic do_req(input logic [3:0] op, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd);
        @(negedge i_clk);
        req_ready_seen = o_req_ready;
        i_req_valid = 1'b1; i_req_op = op; i_req_addr = addr;
        i_req_wdata = wdata; i_req_rd = rd;
        @(negedge i_clk);  // ACCESS
        i_req_valid = 1'b0;
        acc_wr_en = o_ram_wr_en; acc_wr_mask = o_ram_wr_mask;
        acc_wr_data = o_ram_wr_data; acc_wr_addr = o_ram_wr_addr;
        acc_rd_en = o_ram_rd_en; acc_rd_mask = o_ram_rd_mask; acc_rd_addr = o_ram_rd_addr;
        @(negedge i_clk);  // RESP
        got_valid = o_rsp_valid; got_rdata = o_rsp_rdata; got_rd = o_rsp_rd;
        got_is_load = o_rsp_is_load; got_exc = o_rsp_exc;
        i_rsp_ready = 1'b1;
        @(negedge i_clk);  // back to IDLE
        i_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", o_rsp_valid); end
        checks++; if (o_rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h exp 0", o_rsp_rdata); end
        checks++; if ({o_ram_wr_en, o_ram_rd_en} !== 2'b00) begin errors++; $display("FAIL reset_ram_en got %b exp 00", {o_ram_wr_en, o_ram_rd_en}); end
        checks++; if ({o_ram_wr_addr, o_ram_wr_mask, o_ram_wr_data} !== 44'h0) begin errors++; $display("FAIL reset_wr_port got %h exp 0", {o_ram_wr_addr, o_ram_wr_mask, o_ram_wr_data}); end
        checks++; if (o_dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", o_dbg_state); end
        i_rst_n = 1'b1;
        @(negedge i_clk);
        checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got %b exp 1", o_req_ready); end
    endtask

    task automatic test_word();
        do_req(4'b1010, 8'h08, 32'hDEADBEEF, 5'd1);
        checks++; if (req_ready_seen !== 1'b1) begin errors++; $display("FAIL sw_req_ready got %b exp 1", req_ready_seen); end
        checks++; if (acc_wr_en !== 1'b1) begin errors++; $display("FAIL sw_wr_en got %b exp 1", acc_wr_en); end
        checks++; if (acc_wr_mask !== 4'b1111) begin errors++; $display("FAIL sw_wr_mask got %b exp 1111", acc_wr_mask); end
        checks++; if (acc_wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wr_data got %h exp deadbeef", acc_wr_data); end
        checks++; if (acc_wr_addr !== 8'h08) begin errors++; $display("FAIL sw_wr_addr got %h exp 08", acc_wr_addr); end
        checks++; if ({got_valid, got_is_load, got_exc, got_rdata, got_rd} !== {1'b1, 1'b0, 2'b00, 32'h0, 5'd1}) begin errors++; $display("FAIL sw_rsp got v%b l%b e%b d%h r%0d exp v1 l0 e00 d0 r1", got_valid, got_is_load, got_exc, got_rdata, got_rd); end

        do_req(4'b0010, 8'h08, 32'h0, 5'd2);
        checks++; if ({acc_rd_en, acc_rd_mask, acc_rd_addr} !== {1'b1, 4'b1111, 8'h08}) begin errors++; $display("FAIL lw_rd_port got %b %b %h exp 1 1111 08", acc_rd_en, acc_rd_mask, acc_rd_addr); end
        checks++; if (got_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h exp deadbeef", got_rdata); end
        checks++; if ({got_is_load, got_exc, got_rd} !== {1'b1, 2'b00, 5'd2}) begin errors++; $display("FAIL lw_rsp got l%b e%b r%0d exp l1 e00 r2", got_is_load, got_exc, got_rd); end
    endtask

    task automatic test_byte_half();
        // Word 2 becomes 80ADBEEF after this store
        do_req(4'b1000, 8'h0B, 32'h00000080, 5'd3);
        checks++; if (acc_wr_mask !== 4'b1000) begin errors++; $display("FAIL sb_wr_mask got %b exp 1000", acc_wr_mask); end
        checks++; if (acc_wr_data !== 32'h80000000) begin errors++; $display("FAIL sb_wr_data got %h exp 80000000", acc_wr_data); end
        do_req(4'b0000, 8'h0B, 32'h0, 5'd4);
        checks++; if (acc_rd_mask !== 4'b1000) begin errors++; $display("FAIL lb_rd_mask got %b exp 1000", acc_rd_mask); end
        checks++; if (got_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", got_rdata); end
        do_req(4'b0100, 8'h0B, 32'h0, 5'd5);
        checks++; if (got_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata got %h exp 00000080", got_rdata); end
        do_req(4'b0001, 8'h0A, 32'h0, 5'd6);
        checks++; if (acc_rd_mask !== 4'b1100) begin errors++; $display("FAIL lh_rd_mask got %b exp 1100", acc_rd_mask); end
        checks++; if (got_rdata !== 32'hFFFF80AD) begin errors++; $display("FAIL lh_rdata got %h exp ffff80ad", got_rdata); end
        do_req(4'b0101, 8'h0A, 32'h0, 5'd7);
        checks++; if (got_rdata !== 32'h000080AD) begin errors++; $display("FAIL lhu_rdata got %h exp 000080ad", got_rdata); end
        do_req(4'b0000, 8'h09, 32'h0, 5'd8);
        checks++; if (got_rdata !== 32'hFFFFFFBE) begin errors++; $display("FAIL lb1_rdata got %h exp ffffffbe", got_rdata); end
        do_req(4'b1001, 8'h06, 32'h0000A55A, 5'd8);
        checks++; if ({acc_wr_mask, acc_wr_data} !== {4'b1100, 32'hA55A0000}) begin errors++; $display("FAIL sh_wr got %b %h exp 1100 a55a0000", acc_wr_mask, acc_wr_data); end
    endtask

    task automatic test_misaligned();
        int wr0, rd0;
        do_req(4'b1010, 8'h04, 32'h11223344, 5'd9);
        wr0 = wr_pulses; rd0 = rd_pulses;
        do_req(4'b0001, 8'h05, 32'h0, 5'd10);
        checks++; if ({got_exc, got_is_load, got_rdata} !== {2'b01, 1'b1, 32'h0}) begin errors++; $display("FAIL lh_mis_rsp got e%b l%b d%h exp e01 l1 d0", got_exc, got_is_load, got_rdata); end
        do_req(4'b1010, 8'h06, 32'hFFFFFFFF, 5'd11);
        checks++; if (got_exc !== 2'b01) begin errors++; $display("FAIL sw_mis_exc got %b exp 01", got_exc); end
        checks++; if (wr_pulses !== wr0 || rd_pulses !== rd0) begin errors++; $display("FAIL mis_pulses got wr%0d rd%0d exp wr%0d rd%0d", wr_pulses, rd_pulses, wr0, rd0); end
        do_req(4'b0010, 8'h04, 32'h0, 5'd12);
        checks++; if (got_rdata !== 32'h11223344) begin errors++; $display("FAIL mis_ram_unchanged got %h exp 11223344", got_rdata); end
    endtask

    task automatic test_illegal();
        int wr0, rd0;
        wr0 = wr_pulses; rd0 = rd_pulses;
        do_req(4'b1100, 8'h00, 32'h12345678, 5'd13);
        checks++; if ({got_exc, got_rdata, got_rd} !== {2'b10, 32'h0, 5'd13}) begin errors++; $display("FAIL st100_rsp got e%b d%h r%0d exp e10 d0 r13", got_exc, got_rdata, got_rd); end
        do_req(4'b0011, 8'h00, 32'h0, 5'd14);
        checks++; if ({got_exc, got_rdata} !== {2'b10, 32'h0}) begin errors++; $display("FAIL ld011_rsp got e%b d%h exp e10 d0", got_exc, got_rdata); end
        checks++; if (wr_pulses !== wr0 || rd_pulses !== rd0) begin errors++; $display("FAIL illegal_pulses got wr%0d rd%0d exp wr%0d rd%0d", wr_pulses, rd_pulses, wr0, rd0); end
    endtask

    task automatic test_back_to_back();
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_op = 4'b0010; i_req_addr = 8'h08; i_req_rd = 5'd20;
        @(negedge i_clk);  // ACCESS
        checks++; if (o_req_ready !== 1'b0) begin errors++; $display("FAIL access_req_ready got %b exp 0", o_req_ready); end
        i_req_valid = 1'b0;
        @(negedge i_clk);  // RESP, not yet accepted
        for (int c = 0; c < 5; c++) begin
            checks++; if ({o_rsp_valid, o_rsp_rdata, o_rsp_rd, o_req_ready} !== {1'b1, 32'h80ADBEEF, 5'd20, 1'b0}) begin errors++; $display("FAIL hold_c%0d got v%b d%h r%0d rdy%b exp v1 d80adbeef r20 rdy0", c, o_rsp_valid, o_rsp_rdata, o_rsp_rd, o_req_ready); end
            @(negedge i_clk);
        end
        i_rsp_ready = 1'b1;
        i_req_valid = 1'b1; i_req_op = 4'b0010; i_req_addr = 8'h04; i_req_rd = 5'd21;
        #1;
        checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_req_ready got %b exp 1", o_req_ready); end
        @(negedge i_clk);  // ACCESS of second request
        checks++; if ({o_ram_rd_en, o_ram_rd_addr, o_rsp_valid} !== {1'b1, 8'h04, 1'b0}) begin errors++; $display("FAIL b2b_access got en%b a%h v%b exp en1 a04 v0", o_ram_rd_en, o_ram_rd_addr, o_rsp_valid); end
        i_req_valid = 1'b0; i_rsp_ready = 1'b0;
        @(negedge i_clk);
        checks++; if ({o_rsp_valid, o_rsp_rdata, o_rsp_rd} !== {1'b1, 32'h11223344, 5'd21}) begin errors++; $display("FAIL b2b_rsp got v%b d%h r%0d exp v1 d11223344 r21", o_rsp_valid, o_rsp_rdata, o_rsp_rd); end
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_req(4'b1010, 8'h10, 32'hCAFEF00D, 5'd22);
        do_req(4'b0010, 8'h10, 32'h0, 5'd23);
        checks++; if (got_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL pre_rst_lw got %h exp cafef00d", got_rdata); end
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_op = 4'b1010; i_req_addr = 8'h10; i_req_wdata = 32'h12345678; i_req_rd = 5'd24;
        @(negedge i_clk);  // ACCESS of the store to be dropped
        i_req_valid = 1'b0;
        checks++; if (o_ram_wr_en !== 1'b1) begin errors++; $display("FAIL rst_access_wr_en got %b exp 1", o_ram_wr_en); end
        #2 i_rst_n = 1'b0;
        #1;
        checks++; if ({o_ram_wr_en, o_ram_rd_en, o_rsp_valid} !== 3'b000) begin errors++; $display("FAIL rst_drop got wr%b rd%b v%b exp 000", o_ram_wr_en, o_ram_rd_en, o_rsp_valid); end
        checks++; if ({o_rsp_rdata, o_rsp_rd, o_dbg_state} !== {32'h0, 5'd0, 2'd0}) begin errors++; $display("FAIL rst_regs got d%h r%0d s%0d exp 0 0 0", o_rsp_rdata, o_rsp_rd, o_dbg_state); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        do_req(4'b0010, 8'h10, 32'h0, 5'd25);
        checks++; if (got_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_old_value got %h exp cafef00d", got_rdata); end
    endtask

    initial begin
        for (int w = 0; w < 64; w++) mem[w] = 32'h0;
        i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_op = 4'h0; i_req_addr = 8'h0;
        i_req_wdata = 32'h0; i_req_rd = 5'd0; i_rsp_ready = 1'b0;
        test_reset();
        test_word();
        test_byte_half();
        test_misaligned();
        test_illegal();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
